mul_seq: RTL and testbench

Multi-cycle multiply sequencer for the multicycle ARM core. It accepts one MUL/UMULL/SMULL operation from the main controller and runs an iterative shift-add multiplier over several cycles. It then drives the register file write port(s) with RdLo and, for long multiplies, RdHi. It is the only agent that writes multiply results, so the main FSM holds in its execute state while `busy` is high.

---
 rtl/mul_seq.sv | 154 +++++++++++++++
 tb/tb_mul_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiply sequencer for MUL/UMULL/SMULL with register-file writeback.
// Optional macro MUL_SEQ_DUAL_WRITE_EN: long multiplies write RdLo and RdHi in one cycle on two ports.
module mul_seq #(
  parameter int STEP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  output logic        busy,
  input  logic        op_long,
  input  logic        op_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  rd_lo,
  input  logic [3:0]  rd_hi,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        rf_we2,
  output logic [3:0]  rf_wa2,
  output logic [31:0] rf_wd2,
  output logic        done
);

  localparam int N = 32 / STEP_BITS;
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [2:0] {IDLE, MUL, FIX, WB_LO, WB_HI} state_t;

  state_t      r_state, w_next;
  logic [63:0] r_prod;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [5:0]  r_cnt;
  logic        r_sign;
  logic        r_long;
  logic [3:0]  r_rd_lo;
  logic [3:0]  r_rd_hi;

  logic        w_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_partial;

  assign w_neg   = op_long & op_signed;
  // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned
  assign w_mag_a = (w_neg && a[31]) ? (32'd0 - a) : a;
  assign w_mag_b = (w_neg && b[31]) ? (32'd0 - b) : b;

  assign ready = (r_state == IDLE);
  assign busy  = ~ready;

  always_comb begin
    w_partial = '0;
    for (int unsigned j = 0; j < STEP_BITS; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_long   <= 1'b0;
      r_rd_lo  <= '0;
      r_rd_hi  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {32'd0, w_mag_a};
            r_mplier <= w_mag_b;
            r_sign   <= w_neg & (a[31] ^ b[31]);
            r_long   <= op_long;
            r_rd_lo  <= rd_lo;
            r_rd_hi  <= rd_hi;
            r_prod   <= '0;
            r_cnt    <= '0;
          end
        end
        MUL: begin
          r_prod   <= r_prod + w_partial;
          r_mcand  <= r_mcand << STEP_BITS;
          r_mplier <= r_mplier >> STEP_BITS;
          r_cnt    <= r_cnt + 6'd1;
        end
        FIX: begin
          if (r_sign) r_prod <= 64'd0 - r_prod;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    rf_we  = 1'b0;
    rf_wa  = '0;
    rf_wd  = '0;
    rf_we2 = 1'b0;
    rf_wa2 = '0;
    rf_wd2 = '0;
    done   = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = MUL;
      MUL:   if (r_cnt == LAST) w_next = FIX;
      FIX:   w_next = WB_LO;
      WB_LO: begin
        rf_we = (r_rd_lo != 4'hF);
        rf_wa = r_rd_lo;
        rf_wd = r_prod[31:0];
`ifdef MUL_SEQ_DUAL_WRITE_EN
        if (r_long) begin
          rf_we2 = (r_rd_hi != 4'hF);
          rf_wa2 = r_rd_hi;
          rf_wd2 = r_prod[63:32];
          // same destination: the hi half must be the value that lands
          if (r_rd_lo == r_rd_hi) rf_we = 1'b0;
        end
        done   = 1'b1;
        w_next = IDLE;
`else
        if (r_long) begin
          w_next = WB_HI;
        end else begin
          done   = 1'b1;
          w_next = IDLE;
        end
`endif
      end
      WB_HI: begin
        rf_we  = (r_rd_hi != 4'hF);
        rf_wa  = r_rd_hi;
        rf_wd  = r_prod[63:32];
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // a reset arriving during writeback drops the pending result
    if (reset) begin
      rf_we  = 1'b0;
      rf_we2 = 1'b0;
      done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: transaction-level latency/product model checked every cycle,
// plus literal expectations on a shadow register file.
module tb_mul_seq;

  localparam int STEP = 1;
  localparam int N    = 32 / STEP;
`ifdef MUL_SEQ_DUAL_WRITE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam int LAT_MUL  = N + 2;
  localparam int LAT_LONG = DUAL ? N + 2 : N + 3;

  logic        clk = 1'b0;
  logic        reset, start, op_long, op_signed;
  logic [31:0] a, b;
  logic [3:0]  rd_lo, rd_hi;
  logic        ready, busy, rf_we, rf_we2, done;
  logic [3:0]  rf_wa, rf_wa2;
  logic [31:0] rf_wd, rf_wd2;

  mul_seq #(.STEP_BITS(STEP)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
    .op_long(op_long), .op_signed(op_signed), .a(a), .b(b),
    .rd_lo(rd_lo), .rd_hi(rd_hi),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_we2(rf_we2), .rf_wa2(rf_wa2), .rf_wd2(rf_wd2),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Shadow register file: port 2 is applied after port 1 so it wins on a shared address.
  logic [31:0] rf [16] = '{default: 32'hDEAD_BEEF};
  int          wcount = 0;
  always @(posedge clk) begin
    if (rf_we)  begin rf[rf_wa]  <= rf_wd;  wcount = wcount + 1; end
    if (rf_we2) begin rf[rf_wa2] <= rf_wd2; wcount = wcount + 1; end
  end

  // Transaction model: accepted op, its exact product, and cycles elapsed since accept.
  bit          m_act = 1'b0;
  int          m_k   = 0;
  logic [63:0] m_p   = '0;
  logic        m_long = 1'b0;
  logic [3:0]  m_lo = '0, m_hi = '0;
  always @(posedge clk) begin
    logic [63:0] xa, xb;
    int          d;
    d = (m_long && !DUAL) ? N + 3 : N + 2;
    if (reset) begin
      m_act = 1'b0;
      m_k   = 0;
    end else if (m_act) begin
      if (m_k == d) begin m_act = 1'b0; m_k = 0; end
      else m_k = m_k + 1;
    end else if (start) begin
      xa = (op_long && op_signed) ? {{32{a[31]}}, a} : {32'd0, a};
      xb = (op_long && op_signed) ? {{32{b[31]}}, b} : {32'd0, b};
      m_p    = xa * xb;
      m_long = op_long;
      m_lo   = rd_lo;
      m_hi   = rd_hi;
      m_act  = 1'b1;
      m_k    = 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic       e_we, e_we2, e_done;
    logic [3:0] e_wa, e_wa2;
    logic [31:0] e_wd, e_wd2;
    @(negedge clk);
    e_we = 0; e_we2 = 0; e_done = 0; e_wa = '0; e_wa2 = '0; e_wd = '0; e_wd2 = '0;
    if (m_act) begin
      if (m_k == N + 2) begin
        e_wa = m_lo;
        e_wd = m_p[31:0];
        e_we = (m_lo != 4'hF) && !(DUAL && m_long && m_lo == m_hi);
        if (DUAL && m_long) begin
          e_we2 = (m_hi != 4'hF);
          e_wa2 = m_hi;
          e_wd2 = m_p[63:32];
        end
        e_done = !(m_long && !DUAL);
      end else if (m_k == N + 3) begin
        e_wa   = m_hi;
        e_wd   = m_p[63:32];
        e_we   = (m_hi != 4'hF);
        e_done = 1'b1;
      end
    end
    if (reset) begin e_we = 0; e_we2 = 0; e_done = 0; end
    chk("ready",  32'(ready),  32'(!m_act));
    chk("busy",   32'(busy),   32'(m_act));
    chk("done",   32'(done),   32'(e_done));
    chk("rf_we",  32'(rf_we),  32'(e_we));
    chk("rf_wa",  32'(rf_wa),  32'(e_wa));
    chk("rf_wd",  rf_wd,       e_wd);
    chk("rf_we2", 32'(rf_we2), 32'(e_we2));
    chk("rf_wa2", 32'(rf_wa2), 32'(e_wa2));
    chk("rf_wd2", rf_wd2,      e_wd2);
  endtask

  // lat = number of negedge samples from the accept edge up to and including the done sample.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic il,
                        input logic is, input logic [3:0] lo, input logic [3:0] hi,
                        input int poke_at, output int lat);
    chk("ready_before_start", 32'(ready), 32'd1);
    a = ia; b = ib; op_long = il; op_signed = is; rd_lo = lo; rd_hi = hi;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; rd_lo = 4'($urandom); rd_hi = 4'($urandom);
    op_long = 1'($urandom); op_signed = 1'($urandom);
    lat = 1;
    while (!done && lat < 200) begin
      if (lat == poke_at) begin
        start = 1'b1; a = 32'd9; b = 32'd9; op_long = 1'b0; rd_lo = 4'd10;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    int lat;
    int wc0;
    reset = 1'b1; start = 1'b0; op_long = 1'b0; op_signed = 1'b0;
    a = '0; b = '0; rd_lo = '0; rd_hi = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_we",    32'({rf_we, rf_we2}), 32'd0);
    chk("rst_wd",    rf_wd | rf_wd2, 32'd0);

    // MUL 7*6 -> R2 = 0x2A, done 34 samples after accept for STEP_BITS=1
    run_op(32'd7, 32'd6, 1'b0, 1'b0, 4'd2, 4'd0, -1, lat);
    chk("mul_r2", rf[2], 32'h0000_002A);
    chk("mul_lat", 32'(lat), 32'(LAT_MUL));

    // UMULL max*max -> R1 = 1, R3 = 0xFFFFFFFE
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd1, 4'd3, -1, lat);
    chk("umull_r1", rf[1], 32'h0000_0001);
    chk("umull_r3", rf[3], 32'hFFFF_FFFE);
    chk("umull_lat", 32'(lat), 32'(LAT_LONG));

    // SMULL -2*3
    run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1, 4'd5, 4'd6, -1, lat);
    chk("smull_lo", rf[5], 32'hFFFF_FFFA);
    chk("smull_hi", rf[6], 32'hFFFF_FFFF);

    // SMULL min*min: magnitude 2^31 each, product 2^62
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd7, 4'd8, -1, lat);
    chk("smin_lo", rf[7], 32'h0000_0000);
    chk("smin_hi", rf[8], 32'h4000_0000);

    // SMULL 5 * -3 and MUL with op_signed set (ignored)
    run_op(32'd5, 32'hFFFF_FFFD, 1'b1, 1'b1, 4'd12, 4'd13, -1, lat);
    chk("smix_lo", rf[12], 32'hFFFF_FFF1);
    chk("smix_hi", rf[13], 32'hFFFF_FFFF);
    run_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 4'd14, 4'd0, -1, lat);
    chk("mul_sgn_ignored", rf[14], 32'hFFFF_FFFE);

    // Reset during MUL: nothing written, idle right after the reset edge
    wc0 = wcount;
    chk("pre_rst_ready", 32'(ready), 32'd1);
    a = 32'h1234; b = 32'h5678; op_long = 1'b0; op_signed = 1'b0; rd_lo = 4'd11; rd_hi = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    repeat (40) tick();
    chk("mid_rst_nowrite", 32'(wcount - wc0), 32'd0);
    chk("mid_rst_r11", rf[11], 32'hDEAD_BEEF);
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 4'd9, 4'd0, -1, lat);
    chk("post_rst_r9", rf[9], 32'h0000_000F);

    // UMULL 0x10000^2 into the same register: hi (=1) must land
    wc0 = wcount;
    run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 4'd4, 4'd4, -1, lat);
    chk("same_rd_r4", rf[4], 32'h0000_0001);
    chk("same_rd_lat", 32'(lat), 32'(LAT_LONG));
    chk("same_rd_writes", 32'(wcount - wc0), DUAL ? 32'd1 : 32'd2);

    // R15 destination with a start pulse while busy
    run_op(32'd2, 32'd3, 1'b0, 1'b0, 4'd15, 4'd0, 5, lat);
    chk("r15_suppressed", rf[15], 32'hDEAD_BEEF);
    chk("busy_start_ignored", rf[10], 32'hDEAD_BEEF);
    chk("r15_lat", 32'(lat), 32'(LAT_MUL));
    repeat (40) tick();
    chk("r10_still_unwritten", rf[10], 32'hDEAD_BEEF);

    // UMULL 0x80000000*2 back-to-back
    run_op(32'h8000_0000, 32'd2, 1'b1, 1'b0, 4'd0, 4'd1, -1, lat);
    chk("umull_b2b_lo", rf[0], 32'h0000_0000);
    chk("umull_b2b_hi", rf[1], 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
